// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the register-slave FSM state types.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS read/write registers.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*    : write address / data / response channels
//   s_axil_ar*/r*       : read address / data channels
//   reg_q               : flat view of all registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// All outputs come straight from flops; no output depends combinationally on valid/ready.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
    input  logic [2:0]                     s_axil_awprot,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]          s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
    input  logic [2:0]                     s_axil_arprot,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    output logic [DATA_WIDTH-1:0]          s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    // Apply write data byte-by-byte where the strobe is set.
    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < int'(STRB_WIDTH); b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return addr < ADDR_WIDTH'(NUM_REGS * 4);
    endfunction

    // Protection bits carry no meaning for this register file.
    logic w_unused_prot;
    assign w_unused_prot = ^{s_axil_awprot, s_axil_arprot};

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // ---------------- write side ----------------
    wstate_t                r_wstate, w_wstate_nxt;
    logic                   r_aw_held, w_aw_held_nxt;
    logic                   r_w_held, w_w_held_nxt;
    logic [ADDR_WIDTH-1:0]  r_awaddr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [STRB_WIDTH-1:0]  r_wstrb;
    logic                   r_awready, w_awready_nxt;
    logic                   r_wready, w_wready_nxt;
    logic                   r_bvalid, w_bvalid_nxt;
    logic [1:0]             r_bresp, w_bresp_nxt;
    logic                   w_aw_hs, w_w_hs, w_commit;
    logic [ADDR_WIDTH-1:0]  w_wr_addr;
    logic [DATA_WIDTH-1:0]  w_wr_data;
    logic [STRB_WIDTH-1:0]  w_wr_strb;
    logic                   w_wr_in_range;
    logic [IDX_W-1:0]       w_wr_idx;

    assign w_aw_hs = s_axil_awvalid && r_awready;
    assign w_w_hs  = s_axil_wvalid && r_wready;

    // A channel handshaking this cycle is used directly; otherwise the held copy.
    assign w_wr_addr     = r_aw_held ? r_awaddr : s_axil_awaddr;
    assign w_wr_data     = r_w_held  ? r_wdata  : s_axil_wdata;
    assign w_wr_strb     = r_w_held  ? r_wstrb  : s_axil_wstrb;
    assign w_wr_in_range = f_in_range(w_wr_addr);
    assign w_wr_idx      = w_wr_addr[2 +: IDX_W];

    // Write FSM next-state and registered-output decode.
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_aw_held_nxt = r_aw_held;
        w_w_held_nxt  = r_w_held;
        w_awready_nxt = 1'b0;
        w_wready_nxt  = 1'b0;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_commit      = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) w_aw_held_nxt = 1'b1;
                if (w_w_hs)  w_w_held_nxt  = 1'b1;
                if (w_aw_held_nxt && w_w_held_nxt) begin
                    w_commit      = 1'b1;
                    w_wstate_nxt  = W_RESP;
                    w_aw_held_nxt = 1'b0;
                    w_w_held_nxt  = 1'b0;
                    w_bvalid_nxt  = 1'b1;
                    w_bresp_nxt   = w_wr_in_range ? RESP_OKAY : RESP_DECERR;
                end else begin
                    w_awready_nxt = !w_aw_held_nxt;
                    w_wready_nxt  = !w_w_held_nxt;
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    w_wstate_nxt  = W_IDLE;
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Write FSM state and channel registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            if (w_aw_hs) r_awaddr <= s_axil_awaddr;
            if (w_w_hs) begin
                r_wdata <= s_axil_wdata;
                r_wstrb <= s_axil_wstrb;
            end
        end
    end

    // Register file; out-of-range commits leave it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
        end else if (w_commit && w_wr_in_range) begin
            r_regs[w_wr_idx] <= f_merge(r_regs[w_wr_idx], w_wr_data, w_wr_strb);
        end
    end

    // ---------------- read side ----------------
    rstate_t                r_rstate, w_rstate_nxt;
    logic                   r_arready, w_arready_nxt;
    logic                   r_rvalid, w_rvalid_nxt;
    logic [DATA_WIDTH-1:0]  r_rdata, w_rdata_nxt;
    logic [1:0]             r_rresp, w_rresp_nxt;
    logic                   w_ar_hs, w_rd_in_range;
    logic [IDX_W-1:0]       w_rd_idx;

    assign w_ar_hs       = s_axil_arvalid && r_arready;
    assign w_rd_in_range = f_in_range(s_axil_araddr);
    assign w_rd_idx      = s_axil_araddr[2 +: IDX_W];

    // Read FSM next-state; data sampled from pre-edge register contents.
    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_arready_nxt = 1'b0;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        case (r_rstate)
            R_IDLE: begin
                w_arready_nxt = 1'b1;
                if (w_ar_hs) begin
                    w_rstate_nxt  = R_DATA;
                    w_arready_nxt = 1'b0;
                    w_rvalid_nxt  = 1'b1;
                    w_rdata_nxt   = w_rd_in_range ? r_regs[w_rd_idx] : '0;
                    w_rresp_nxt   = w_rd_in_range ? RESP_OKAY : RESP_DECERR;
                end
            end
            R_DATA: begin
                if (s_axil_rready) begin
                    w_rstate_nxt  = R_IDLE;
                    w_arready_nxt = 1'b1;
                    w_rvalid_nxt  = 1'b0;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read FSM state and channel registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
        end
    end

    // ---------------- outputs ----------------
    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_wready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;

    for (genvar gi = 0; gi < int'(NUM_REGS); gi++) begin : g_regq
        assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_axil_reg_slave;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned NR = 16;
    localparam int          TO = 50;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [AW-1:0]   awaddr = '0;
    logic [2:0]      awprot = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [SW-1:0]   wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [AW-1:0]   araddr = '0;
    logic [2:0]      arprot = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b0;
    logic [NR*DW-1:0] reg_q;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axil_reg_slave dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (awprot),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .reg_q          (reg_q)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [DW-1:0] m_regs [NR];
    logic [AW-1:0] aw_q [$];
    logic [DW-1:0] wd_q [$];
    logic [SW-1:0] ws_q [$];
    bit            b_pend, r_pend, rdy_en;
    logic [1:0]    b_exp_resp, r_exp_resp;
    logic [DW-1:0] r_exp_data;

    function automatic logic [NR*DW-1:0] m_flat();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < int'(NR); i++) v[i*DW +: DW] = m_regs[i];
        return v;
    endfunction

    // Compare at every falling edge, then fold in the handshakes the next rising edge will see.
    always @(negedge clk) begin
        bit e_aw, e_w, e_ar;
        if (!rst) begin
            for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
            aw_q.delete(); wd_q.delete(); ws_q.delete();
            b_pend = 0; r_pend = 0; rdy_en = 0;
            chk("rst_awready", awready, 0);
            chk("rst_wready", wready, 0);
            chk("rst_arready", arready, 0);
            chk("rst_bvalid", bvalid, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_bresp", bresp, 0);
            chk("rst_rresp", rresp, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_reg_q", reg_q, 0);
        end else begin
            e_aw = rdy_en && !b_pend && (aw_q.size() == 0);
            e_w  = rdy_en && !b_pend && (wd_q.size() == 0);
            e_ar = rdy_en && !r_pend;
            chk("reg_q", reg_q, m_flat());
            chk("awready", awready, e_aw);
            chk("wready", wready, e_w);
            chk("arready", arready, e_ar);
            chk("bvalid", bvalid, b_pend);
            if (b_pend) chk("bresp", bresp, b_exp_resp);
            chk("rvalid", rvalid, r_pend);
            if (r_pend) begin
                chk("rdata", rdata, r_exp_data);
                chk("rresp", rresp, r_exp_resp);
            end
            if (b_pend && bready) b_pend = 0;
            if (r_pend && rready) r_pend = 0;
            // Read observes register contents from before any same-edge write.
            if (arvalid && e_ar) begin
                r_pend = 1;
                if (araddr < 32'h40) begin
                    r_exp_data = m_regs[araddr[5:2]];
                    r_exp_resp = 2'b00;
                end else begin
                    r_exp_data = '0;
                    r_exp_resp = 2'b11;
                end
            end
            if (awvalid && e_aw) aw_q.push_back(awaddr);
            if (wvalid && e_w) begin
                wd_q.push_back(wdata);
                ws_q.push_back(wstrb);
            end
            if (aw_q.size() > 0 && wd_q.size() > 0) begin
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                logic [SW-1:0] s;
                a = aw_q.pop_front();
                d = wd_q.pop_front();
                s = ws_q.pop_front();
                if (a < 32'h40) begin
                    for (int b = 0; b < int'(SW); b++)
                        if (s[b]) m_regs[a[5:2]][8*b +: 8] = d[8*b +: 8];
                    b_exp_resp = 2'b00;
                end else begin
                    b_exp_resp = 2'b11;
                end
                b_pend = 1;
            end
            rdy_en = 1;
        end
    end

    // ---------------- master tasks (enter and leave at posedge + 1) ----------------
    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, got = 0;
        resp = 2'bxx;
        while (!(aw_done && w_done) && cyc < TO) begin
            awaddr  = a;
            wdata   = d;
            wstrb   = s;
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        awvalid = 0;
        wvalid  = 0;
        chk("write_accept", {aw_done, w_done}, 2'b11);
        cyc = 0;
        while (!got && cyc < TO) begin
            bready = (cyc >= b_dly);
            @(negedge clk);
            if (bvalid && bready) begin
                got  = 1;
                resp = bresp;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bready = 0;
        chk("write_bresp_seen", got, 1);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int ar_dly, input int r_dly,
                            output logic [DW-1:0] d, output logic [1:0] resp);
        int cyc = 0;
        bit ar_done = 0, got = 0;
        d = 'x;
        resp = 2'bxx;
        while (!ar_done && cyc < TO) begin
            araddr  = a;
            arvalid = (cyc >= ar_dly);
            @(negedge clk);
            if (arvalid && arready) ar_done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 0;
        chk("read_accept", ar_done, 1);
        cyc = 0;
        while (!got && cyc < TO) begin
            rready = (cyc >= r_dly);
            @(negedge clk);
            if (rvalid && rready) begin
                got  = 1;
                d    = rdata;
                resp = rresp;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rready = 0;
        chk("read_rvalid_seen", got, 1);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 9) < 8) return AW'($urandom_range(0, 63));
        return AW'($urandom()) | 32'h40;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d;
        logic [1:0]    br, rr;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        logic [SW-1:0] ws;
        int mode, d0, d1, d2, d3;

        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("ready_before_first_edge", {awready, wready, arready}, 3'b000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_first_edge", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;

        // All registers read back zero after reset.
        for (int i = 0; i < 16; i++) begin
            axi_read(AW'(i * 4), 0, 0, d, rr);
            chk("reset_read_data", d, 32'h0);
            chk("reset_read_resp", rr, 2'b00);
        end

        // AW leads W by two cycles.
        axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 2, 0, br);
        chk("aw_first_bresp", br, 2'b00);
        axi_read(32'h08, 0, 0, d, rr);
        chk("aw_first_readback", d, 32'hDEADBEEF);

        // Partial strobe merge.
        axi_write(32'h04, 32'h11223344, 4'hF, 1, 0, 0, br);
        axi_write(32'h04, 32'hAABBCCDD, 4'h5, 0, 0, 1, br);
        chk("strb5_bresp", br, 2'b00);
        axi_read(32'h04, 0, 0, d, rr);
        chk("strb5_readback", d, 32'h11BB33DD);

        // Out-of-range write and read in parallel.
        fork
            axi_write(32'h40, 32'h55555555, 4'hF, 0, 0, 0, br);
            axi_read(32'h7C, 0, 0, d, rr);
        join
        chk("oor_bresp", br, 2'b11);
        chk("oor_rresp", rr, 2'b11);
        chk("oor_rdata", d, 32'h0);
        chk("oor_reg1_intact", reg_q[1*DW +: DW], 32'h11BB33DD);
        chk("oor_reg2_intact", reg_q[2*DW +: DW], 32'hDEADBEEF);

        // Backpressure on both response channels.
        fork
            axi_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 5, br);
            axi_read(32'h08, 0, 5, d, rr);
        join
        chk("stall_bresp", br, 2'b00);
        chk("stall_rdata", d, 32'hDEADBEEF);

        // Zero strobe leaves the register alone.
        axi_write(32'h08, 32'h0, 4'h0, 0, 0, 0, br);
        chk("strb0_bresp", br, 2'b00);
        axi_read(32'h0A, 0, 0, d, rr);
        chk("strb0_readback", d, 32'hDEADBEEF);

        // Write commit and read of the same register on one edge.
        fork
            axi_write(32'h14, 32'h12345678, 4'hF, 0, 0, 0, br);
            axi_read(32'h14, 0, 0, d, rr);
        join
        chk("same_edge_old_value", d, 32'h0);
        axi_read(32'h14, 0, 0, d, rr);
        chk("same_edge_new_value", d, 32'h12345678);

        // Reset while the write response is pending.
        awaddr = 32'h0C; wdata = 32'h5; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk("midrst_bvalid_before", bvalid, 1);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("midrst_bvalid_dropped", bvalid, 0);
        chk("midrst_reg3_cleared", reg_q[3*DW +: DW], 32'h0);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1;
        axi_read(32'h0C, 0, 0, d, rr);
        chk("midrst_readback", d, 32'h0);

        // Randomized mixed traffic.
        for (int it = 0; it < 200; it++) begin
            wa = rnd_addr();
            ra = rnd_addr();
            wd = DW'($urandom());
            ws = SW'($urandom_range(0, 15));
            mode = $urandom_range(0, 2);
            d0 = $urandom_range(0, 3);
            d1 = $urandom_range(0, 3);
            d2 = $urandom_range(0, 3);
            d3 = $urandom_range(0, 3);
            case (mode)
                0: axi_write(wa, wd, ws, d0, d1, d2, br);
                1: axi_read(ra, d0, d3, d, rr);
                default: fork
                    axi_write(wa, wd, ws, d0, d1, d2, br);
                    axi_read(ra, d1, d3, d, rr);
                join
            endcase
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, byte-strobe width.
REQ-004 Parameter NUM_REGS, default 16, register count (power of two).
REQ-005 Port clk  in  1  single clock; all state on rising edge.
REQ-006 Port rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-007 Ports s_axil_awaddr in ADDR_WIDTH, s_axil_awprot in 3, s_axil_awvalid in 1, s_axil_awready out 1: write address channel.
REQ-008 Ports s_axil_wdata in DATA_WIDTH, s_axil_wstrb in STRB_WIDTH, s_axil_wvalid in 1, s_axil_wready out 1: write data channel.
REQ-009 Ports s_axil_bresp out 2, s_axil_bvalid out 1, s_axil_bready in 1: write response channel.
REQ-010 Ports s_axil_araddr in ADDR_WIDTH, s_axil_arprot in 3, s_axil_arvalid in 1, s_axil_arready out 1: read address channel.
REQ-011 Ports s_axil_rdata out DATA_WIDTH, s_axil_rresp out 2, s_axil_rvalid out 1, s_axil_rready in 1: read data channel.
REQ-012 Port reg_q  out  NUM_REGS*DATA_WIDTH  flat view of all registers, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-013 Register index = addr[2+log2(NUM_REGS)-1:2]; addr bits [1:0] ignored; addr >= NUM_REGS*4 is out of range.
REQ-014 awprot/arprot accepted and ignored.
REQ-015 Write FSM states: W_IDLE, W_RESP.
REQ-016 In W_IDLE, awready = 1 while no AW held; wready = 1 while no W held; AW and W accepted independently, either order or same cycle.
REQ-017 On the edge where both AW and W are held (held or handshaking that cycle), write commits: per byte b, reg[idx] byte b <= wdata byte b if wstrb[b]=1; FSM -> W_RESP, bvalid = 1 next cycle.
REQ-018 In-range write: bresp = 2'b00 (OKAY); out-of-range: no register change, bresp = 2'b11 (DECERR).
REQ-019 In W_RESP: awready = wready = 0; bvalid and bresp held stable until bvalid&bready; then -> W_IDLE, holds cleared, bvalid = 0 next cycle.
REQ-020 wstrb = 0 with in-range address: no change, bresp OKAY.
REQ-021 Read FSM states: R_IDLE, R_DATA.
REQ-022 In R_IDLE, arready = 1; on arvalid&arready, rdata <= reg[idx] (registered), -> R_DATA; rvalid = 1 exactly one cycle after the AR handshake.
REQ-023 In-range read: rresp = 2'b00; out-of-range: rdata = 0, rresp = 2'b11.
REQ-024 In R_DATA: arready = 0; rvalid/rdata/rresp stable until rvalid&rready; then -> R_IDLE.
REQ-025 Read and write channels fully independent; both may be active in the same cycle.
REQ-026 Write commit and AR handshake to same register on same edge: read returns pre-write value.
REQ-027 No output depends combinationally on any valid/ready input (all outputs registered or state-decoded).
REQ-028 reg_q reflects a committed write on the cycle after the commit edge.

Reset
REQ-029 While rst = 0: both FSMs idle, AW/W holds cleared, all registers = 0, awready = wready = arready = 0, bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0.
REQ-030 awready, wready, arready rise to 1 on the first edge after rst deasserts.
REQ-031 Reset mid-transaction abandons it: pending write not committed, pending B/R responses dropped.

Structure
REQ-032 Shared package axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, write/read FSM state enums.
REQ-033 Single module, no sub-modules; byte-enable merge as a local function.

Verification
REQ-034 Reset then read all 16 regs -> rdata 0x00000000, rresp OKAY, rvalid one cycle after each AR.
REQ-035 AW 0x08 two cycles before W 0xDEADBEEF strb 0xF -> single B OKAY; read 0x08 -> 0xDEADBEEF.
REQ-036 Reg 0x04 = 0x11223344, write 0xAABBCCDD strb 0x5 -> read 0x04 -> 0x11BB33DD.
REQ-037 Write 0x40 and read 0x7C -> bresp 2'b11, rresp 2'b11, rdata 0, no register changed.
REQ-038 Hold bready = 0 and rready = 0 for 5 cycles -> bvalid/rvalid and payloads stable; awready/wready/arready stay 0.
REQ-039 rst low during W_RESP of write 0x0C=0x5 -> bvalid drops to 0, reg 0x0C = 0 after reset.
